mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Two-port memory arbiter bus: requester ports and memory side.
// slave = arbiter view, master = requester/memory-model view.
interface mem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port data memory arbiter: fixed port-0 priority with starvation guard.
// Ports: clk, reset (sync, active high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic          oor;
  logic          p1_wins;
  logic [31:0]   rd_cap;

  assign oor = |addr_q[31:10];

  // Port 1 only overrides port 0 once it has waited MAX_WAIT grants.
  assign p1_wins = bus.m1_req &&
                   (!bus.m0_req || wait_cnt_q == WMAX);

  assign rd_cap = (we_q || oor) ? 32'h0 : bus.mem_rdata;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.m0_ack    = 1'b0;
    bus.m0_err    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.m1_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = ACCESS;
          if (p1_wins) begin
            gnt_d      = 1'b1;
            wait_cnt_d = '0;
            we_d       = bus.m1_we;
            addr_d     = bus.m1_addr;
            wdata_d    = bus.m1_wdata;
          end else begin
            gnt_d   = 1'b0;
            we_d    = bus.m0_we;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
            if (!bus.m1_req)
              wait_cnt_d = '0;
            else if (wait_cnt_q != WMAX)
              wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end
      end
      ACCESS: begin
        state_d       = RESP;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_read  = !oor && !we_q;
        bus.mem_write = !oor && we_q;
        if (gnt_q)
          rdata1_d = rd_cap;
        else
          rdata0_d = rd_cap;
      end
      RESP: begin
        state_d = IDLE;
        if (gnt_q) begin
          bus.m1_ack = 1'b1;
          bus.m1_err = oor;
        end else begin
          bus.m0_ack = 1'b1;
          bus.m0_err = oor;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Scoreboard queues hold expected strobes and responses.
module tb_mem_arbiter;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strb_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk;
  logic reset;
  logic [31:0] mem [256];

  int n_cmp;
  int n_bad;
  int cyc;
  int ack_n;
  int ack0_n;
  int last_ack_cyc;
  strb_t sq [$];
  resp_t q0 [$];
  resp_t q1 [$];
  int ack_log [$];
  int ack_cyc [$];

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk)
    if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic on_ack(input int p);
    resp_t r;
    logic [31:0] rd;
    logic        er;
    logic        oth;
    rd  = p ? bus.m1_rdata : bus.m0_rdata;
    er  = p ? bus.m1_err : bus.m0_err;
    oth = p ? bus.m0_err : bus.m1_err;
    chk("other_err", {31'b0, oth}, 32'h0);
    if ((p ? q1.size() : q0.size()) == 0) begin
      chk(p ? "unexp_ack1" : "unexp_ack0", 32'h1, 32'h0);
    end else begin
      r = p ? q1.pop_front() : q0.pop_front();
      chk(p ? "err1" : "err0", {31'b0, er}, {31'b0, r.err});
      chk(p ? "rdata1" : "rdata0", rd, r.rdata);
    end
    ack_log.push_back(p);
    ack_cyc.push_back(cyc);
    last_ack_cyc = cyc;
    if (p == 0) ack0_n++;
    ack_n++;
  endtask

  always @(negedge clk) begin
    strb_t s;
    if (!reset && (bus.mem_read || bus.mem_write)) begin
      if (sq.size() == 0) begin
        chk("stray_strobe",
            {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
      end else begin
        s = sq.pop_front();
        chk("strb_kind", {30'b0, bus.mem_read, bus.mem_write},
            s.we ? 32'h1 : 32'h2);
        chk("strb_addr", bus.mem_addr, s.addr);
        if (s.we) chk("strb_wdata", bus.mem_wdata, s.wdata);
      end
    end
    if (bus.m0_ack && bus.m1_ack) chk("dual_ack", 32'h1, 32'h0);
    if ((bus.m0_err && !bus.m0_ack) || (bus.m1_err && !bus.m1_ack))
      chk("err_no_ack", 32'h1, 32'h0);
    if (bus.m0_ack) on_ack(0);
    else if (bus.m1_ack) on_ack(1);
  end

  task automatic drive(input int p, input logic rq, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.m0_req = rq; bus.m0_we = we;
      bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = rq; bus.m1_we = we;
      bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic expect_xfer(input int p, input logic we,
                             input logic [31:0] a,
                             input logic [31:0] d);
    resp_t r;
    strb_t s;
    r.err   = (a[31:10] != 22'h0);
    r.rdata = (we || r.err) ? 32'h0 : mem[a[9:2]];
    s.we    = we;
    s.addr  = a;
    s.wdata = d;
    if (!r.err) sq.push_back(s);
    if (p == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && ack_n < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (ack_n < target) chk("ack_timeout", 32'(ack_n), 32'(target));
  endtask

  task automatic xfer(input int p, input logic we,
                      input logic [31:0] a, input logic [31:0] d);
    int n;
    int c0;
    expect_xfer(p, we, a, d);
    drive(p, 1'b1, we, a, d);
    n  = ack_n;
    c0 = cyc;
    wait_acks(n + 1, 20);
    if (ack_n > n) chk("ack_latency", 32'(last_ack_cyc - c0), 32'd2);
    drive(p, 1'b0, we, a, d);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int seq [10];
    int base;
    int n;
    seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    n_cmp = 0; n_bad = 0; cyc = 0; ack_n = 0; ack0_n = 0;
    last_ack_cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 3);
    mem[2] = 32'h0000_005B;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", {30'b0, bus.m0_ack, bus.m1_ack}, 32'h0);
    chk("rst_strb", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("rst_maddr", bus.mem_addr, 32'h0);
    chk("rst_rdata0", bus.m0_rdata, 32'h0);
    chk("rst_rdata1", bus.m1_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    #1;

    xfer(0, 1'b0, 32'h0000_0008, 32'h0);
    xfer(1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    chk("rdata0_hold", bus.m0_rdata, 32'h0000_005B);
    chk("mem_written", mem[16], 32'hDEAD_BEEF);

    // reset in ACCESS of a port-1 write, request held through reset
    q1.push_back('{1'b0, 32'h0});
    sq.push_back('{1'b1, 32'h0000_0044, 32'hCAFE_F00D});
    sq.push_back('{1'b1, 32'h0000_0044, 32'hCAFE_F00D});
    drive(1, 1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D);
    n = ack_n;
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rstacc_ack", {30'b0, bus.m0_ack, bus.m1_ack}, 32'h0);
    chk("rstacc_strb", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("rstacc_maddr", bus.mem_addr, 32'h0);
    chk("rstacc_mwdata", bus.mem_wdata, 32'h0);
    chk("rstacc_rdata0", bus.m0_rdata, 32'h0);
    chk("rstacc_nack", 32'(ack_n), 32'(n));
    reset = 1'b0;
    wait_acks(n + 1, 20);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;

    xfer(0, 1'b0, 32'h0000_0400, 32'h0);
    xfer(1, 1'b0, 32'h0000_0020, 32'h0);
    xfer(0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);

    // port 0 raises during port 1's access and drops before its grant
    expect_xfer(1, 1'b0, 32'h0000_0024, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    n = ack0_n;
    @(negedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
    @(negedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    #1;
    chk("dropped_no_ack", 32'(ack0_n), 32'(n));

    // both ports requesting back-to-back
    ack_log.delete();
    ack_cyc.delete();
    foreach (seq[i])
      expect_xfer(seq[i], 1'b0,
                  seq[i] ? 32'h0000_0020 : 32'h0000_0010, 32'h0);
    base = ack_n;
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    wait_acks(base + 10, 60);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    if (ack_log.size() >= 10) begin
      foreach (seq[i]) chk("grant_order", 32'(ack_log[i]), 32'(seq[i]));
      for (int i = 0; i < 9; i++)
        chk("ack_spacing", 32'(ack_cyc[i + 1] - ack_cyc[i]), 32'd3);
    end
    repeat (4) @(negedge clk);
    #1;
    chk("sb_empty", 32'(q0.size() + q1.size() + sq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
